// File: rtl/dec_scan_pkg.sv
// Shared types and sizes for the 3-to-8 decoder scan controller.
// Holds FSM state encoding and index/dwell widths.
package dec_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SEL_W   = 3;
  localparam int NUM_IDX = 8;
  localparam int DWELL_W = 4;

endpackage

// File: rtl/dwell_cnt.sv
// Dwell counter: counts cycles spent on one decoder index, tc at DWELL-1.
// Latency: tc is decoded from the count register, same cycle.
// Backpressure: none; clr wins over inc, inc at tc wraps to zero.
module dwell_cnt
  import dec_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [DWELL_W-1:0] cnt;

  assign tc = (cnt == DWELL_W'(DWELL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (inc && tc)) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/dec_scan_ctrl.sv
// Scans a 3-to-8 decoder through all 8 indices, holding each for DWELL cycles.
// Latency: all outputs registered, one edge after the deciding inputs.
// Backpressure: none; start ignored unless IDLE, stop aborts; DEC_SCAN_DIR_EN adds dir.
module dec_scan_ctrl
  import dec_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
`ifdef DEC_SCAN_DIR_EN
  input  logic             dir,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             busy,
  output logic             done
);

  state_t             state, state_n;
  logic [SEL_W-1:0]   sel_n;
  logic               en_n, busy_n, done_n;
  logic               cnt_clr, cnt_inc, tc;
  logic               dir_eff;
  logic [SEL_W-1:0]   first_idx, last_idx;

`ifdef DEC_SCAN_DIR_EN
  assign dir_eff = dir;
`else
  assign dir_eff = 1'b0;
`endif

  assign first_idx = dir_eff ? SEL_W'(NUM_IDX - 1) : '0;
  assign last_idx  = dir_eff ? '0 : SEL_W'(NUM_IDX - 1);

  dwell_cnt #(.DWELL(DWELL)) u_dwell_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      en    <= en_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = '0;
    en_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = SCAN;
          sel_n   = first_idx;
          en_n    = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SCAN: begin
        // stop outranks both the wrap and the completion decision
        if (stop) begin
          state_n = IDLE;
        end else begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
          sel_n   = sel;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          if (tc) begin
            if (sel != last_idx) begin
              sel_n = dir_eff ? sel - SEL_W'(1) : sel + SEL_W'(1);
            end else if (cont) begin
              sel_n = first_idx;
            end else begin
              state_n = DONE;
              sel_n   = '0;
              en_n    = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
